// File: rtl/mac_seq_if.sv
// Operand/result bundle for mac_seq: valid/ready operand handshake in, accumulator result out.
// master drives operands and modes; slave (the MAC) returns ready, result, pulse and overflow.
interface mac_seq_if #(
  parameter int W     = 8,
  parameter int ACC_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     opa;
  logic [W-1:0]     opb;
  logic             signed_en;
  logic             acc_load;
  logic [ACC_W-1:0] out;
  logic             out_valid;
  logic             ovf;

  modport master (
    output in_valid, opa, opb, signed_en, acc_load,
    input  in_ready, out, out_valid, ovf
  );

  modport slave (
    input  in_valid, opa, opb, signed_en, acc_load,
    output in_ready, out, out_valid, ovf
  );
endinterface

// File: rtl/mac_seq.sv
// Sequential shift-add MAC with saturating accumulator; result W+1 cycles after accept.
// One operand pair in flight: in_ready is low from accept until the result pulse.
module mac_seq #(
  parameter int W     = 8,
  parameter int ACC_W = 20
) (
  input  logic     clk,
  input  logic     clr,
  mac_seq_if.slave bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ACC} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [W-1:0]     a_mag, b_mag;
  logic             neg, smode, load;
  logic [2*W-1:0]   prod;
  logic [ACC_W-1:0] acc;
  logic             vld;
  logic             ovf_q;

  logic [W-1:0]     opa_mag, opb_mag;
  logic             sgn;
  logic [2*W-1:0]   step_add;
  logic [2*W-1:0]   prod_s;
  logic [ACC_W:0]   p_ext, b_ext, sum;
  logic [ACC_W-1:0] res;
  logic             sat;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nxt = BUSY;
      BUSY:    if (cnt == CW'(W - 1)) state_nxt = ACC;
      ACC:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out       = acc;
    bus.out_valid = vld;
    bus.ovf       = ovf_q;
  end

  // Signed operands are reduced to magnitudes; -2^(W-1) maps to 2^(W-1) unsigned.
  always_comb begin
    opa_mag = (bus.signed_en && bus.opa[W-1]) ? (~bus.opa + W'(1)) : bus.opa;
    opb_mag = (bus.signed_en && bus.opb[W-1]) ? (~bus.opb + W'(1)) : bus.opb;
    sgn     = bus.signed_en & (bus.opa[W-1] ^ bus.opb[W-1]);
  end

  always_comb begin
    step_add = {{W{1'b0}}, b_mag} << cnt;
  end

  // One extra bit of headroom is enough: |product| <= 2^(ACC_W-2) in signed mode.
  always_comb begin
    prod_s = (smode && neg) ? (~prod + (2*W)'(1)) : prod;
    p_ext  = {{(ACC_W + 1 - 2*W){smode & prod_s[2*W-1]}}, prod_s};
    b_ext  = load ? '0 : {smode & acc[ACC_W-1], acc};
    sum    = p_ext + b_ext;
    sat    = 1'b0;
    res    = sum[ACC_W-1:0];
    if (smode) begin
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        sat = 1'b1;
        res = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (sum[ACC_W]) begin
      sat = 1'b1;
      res = {ACC_W{1'b1}};
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      a_mag <= '0;
      b_mag <= '0;
      neg   <= 1'b0;
      smode <= 1'b0;
      load  <= 1'b0;
      prod  <= '0;
      cnt   <= '0;
      acc   <= '0;
      vld   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      vld <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_mag <= opa_mag;
            b_mag <= opb_mag;
            neg   <= sgn;
            smode <= bus.signed_en;
            load  <= bus.acc_load;
            prod  <= '0;
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (a_mag[cnt]) prod <= prod + step_add;
          cnt <= cnt + CW'(1);
        end
        ACC: begin
          acc <= res;
          vld <= 1'b1;
          if (sat)       ovf_q <= 1'b1;
          else if (load) ovf_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mac_seq.md
# mac_seq

Parametrised sequential multiply-accumulate unit. Accepts one operand pair per transaction over a valid/ready handshake, forms the product with a W-step shift-add multiplier, and adds it into a saturating accumulator. Supports signed and unsigned operation per transaction. It serves as the reusable MAC engine for filter and datapath blocks that do not need single-cycle multiply throughput.

## Interface
- W, default 8: operand width, at least 2.
- ACC_W, default 20: accumulator and `out` width, at least 2*W.
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair on `opa`/`opb` is valid.
- in_ready  out  1  block can accept an operand pair.
- opa  in  W  multiplier operand.
- opb  in  W  multiplicand operand.
- signed_en  in  1  treat operands and accumulator as two's complement; sampled at accept.
- acc_load  in  1  start a new sum: `out` becomes the product, not `out`+product; sampled at accept.
- out  out  ACC_W  accumulator value.
- out_valid  out  1  one-cycle pulse when `out` has just been updated.
- ovf  out  1  sticky saturation flag.

## Operation
- States are IDLE, BUSY and ACC.
  - `in_ready` is 1 only in IDLE.
  - Accept happens on an edge where `in_valid && in_ready`.
- On accept:
  - Latch `opa`, `opb`, `signed_en` and `acc_load`.
  - Clear the product register (2W bits) and the step counter.
  - Go to BUSY.
- Operand preparation in signed mode:
  - Latch the magnitudes of both operands.
  - Latch the result sign as `opa[W-1]` XOR `opb[W-1]`.
  - The magnitude of -2^(W-1) is 2^(W-1), held unsigned in W bits.
- BUSY runs exactly W edges, with step counter i = 0..W-1.
  - At step i, if multiplier bit i is 1, add the multiplicand shifted left by i to the product.
  - After step W-1, go to ACC.
- ACC is a single edge:
  - In signed mode, negate the product if the sign is set.
  - Extend the product to ACC_W+1 bits: sign-extend in signed mode, zero-extend otherwise.
  - Add it to the base. The base is 0 if `acc_load`, else `out`, interpreted in the current mode.
  - Saturate the sum to ACC_W bits.
    - Signed range: [-2^(ACC_W-1), 2^(ACC_W-1)-1].
    - Unsigned range: [0, 2^ACC_W-1].
  - Write `out`, pulse `out_valid` and go to IDLE.
- Overflow flag `ovf`:
  - Set in ACC when saturation clamps the sum.
  - Cleared in ACC of an `acc_load` transaction that does not saturate.
  - Cleared otherwise only by `clr`.
- Operand inputs and mode inputs are ignored outside the accept edge. Changes while BUSY have no effect.
- Reset (`clr`=1, at any time, including mid-BUSY) takes effect immediately:
  - State IDLE, `out`=0, `out_valid`=0, `ovf`=0, `in_ready`=1.
  - Product register and counter are cleared.
  - Any in-flight transaction is discarded and produces no `out_valid`.

## Timing
- Accept at edge k. BUSY steps occur at edges k+1..k+W. ACC occurs at edge k+W+1.
- `out` and `out_valid` are updated at edge k+W+1. Latency is W+1 cycles.
- `out_valid` is high for exactly the one cycle after edge k+W+1.
- `in_ready` returns high in that same cycle. The earliest next accept is edge k+W+2.
- Maximum throughput is one transaction per W+2 cycles.
- `out` holds its value between updates.

## Test plan
All scenarios use W=8 and ACC_W=20 unless stated.
- Reset: assert `clr` with inputs toggling -> `out`=0, `out_valid`=0, `ovf`=0, `in_ready`=1 with no clock edge needed.
- Unsigned accumulate:
  - Stimulus: opa=1..10, opb=10, `acc_load`=1 on the first transaction only, `in_valid` held high.
  - Required: 10 `out_valid` pulses with `out` = 10, 30, 60, …, 550.
  - Required: each pulse exactly 9 cycles after its accept, accepts spaced 10 cycles, `in_ready` low between them.
  - Required: changes to `opa` while BUSY are ignored.
- Signed:
  - `acc_load`=1, opa=8'hFD (-3), opb=7 -> `out`=20'hFFFEB (-21).
  - Then opa=8'h80, opb=8'h80 -> `out`=16363.
  - Then opa=8'h7F, opb=8'h80 -> `out`=107 (16363 - 16256).
- Saturation, ACC_W=16, unsigned:
  - `acc_load` 255×255 -> `out`=65025, `ovf`=0.
  - Then 255×255 -> `out`=65535, `ovf`=1.
  - Then 1×1 -> `out`=65535, `ovf` still 1.
  - Then `acc_load` 2×3 -> `out`=6, `ovf`=0.
- Signed saturation, ACC_W=16:
  - Repeated 8'h80×8'h7F (-16256) from `acc_load`.
  - Required: the third result clamps to -32768 with `ovf`=1.
- Reset mid-operation:
  - Assert `clr` for one cycle at the 4th BUSY step.
  - Required: `out`=0 and no `out_valid` pulse.
  - Required: the next transaction, 5×6 with `acc_load`=0, yields `out`=30 after 9 cycles.
